spart_fifo_irq: RTL



---
 rtl/spart_fifo_irq.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/spart_fifo_irq.sv
// spart_fifo_irq: 8N1 UART slave with TX/RX FIFOs, sticky W1C error flags,
// control register and a registered level interrupt.
module spart_fifo_irq #(
  parameter int               FIFO_DEPTH  = 8,
  parameter logic [3:0]       BASE_NIBBLE = 4'hF,
  parameter int               DIV_W       = 13,
  parameter logic [DIV_W-1:0] DEFAULT_DIV = 13'h01B2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] bus_addrData_i,
  input  logic [3:0]  bus_byteEnables_i,
  input  logic [7:0]  bus_burstSize_i,
  input  logic        bus_readNWrite_i,
  input  logic        bus_beginTransaction_i,
  input  logic        bus_endTransaction_i,
  input  logic        bus_dataValid_i,
  output logic [31:0] bus_addrData_o,
  output logic        bus_endTransaction_o,
  output logic        bus_dataValid_o,
  output logic        bus_busy_o,
  output logic        bus_error_o,
  output logic        irq,
  output logic        TX,
  input  logic        RX
);
  localparam int AW = $clog2(FIFO_DEPTH);

  // Bus handshake: a begin with a matching address nibble in IDLE is answered
  // by exactly one RESP cycle carrying endTransaction_o/dataValid_o; write data
  // is taken from bus_addrData_i during RESP; begins seen in RESP are dropped.
  typedef enum logic {BUS_IDLE, BUS_RESP} bus_state_t;
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_t;

  bus_state_t  bus_state_q, bus_state_d;
  uart_state_t tx_state_q, tx_state_d, rx_state_q, rx_state_d;
  logic [1:0]  reg_q, reg_d;
  logic        rnw_q, rnw_d, bad_q, bad_d;
  logic [DIV_W-1:0] div_q, div_d, tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [2:0]  ctrl_q, ctrl_d, tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
  logic        rxovr_q, rxovr_d, frm_q, frm_d, txovf_q, txovf_d;
  logic [7:0]  tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d;
  logic        tx_line_q, tx_line_d, irq_q, irq_d;
  logic        rx_s1_q, rx_s2_q, rx_prev_q;
  logic [AW:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d, rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [7:0]  tx_mem [FIFO_DEPTH];
  logic [7:0]  rx_mem [FIFO_DEPTH];

  logic        resp, wr_en, rd_en, tx_empty, tx_full, rx_empty, rx_full, tx_idle;
  logic        tx_pop, tx_push_ok, rx_pop, rx_push_req, rx_push_ok, frm_set;
  logic [AW:0] tx_count, rx_count;
  logic [7:0]  tx_free8, rx_count8;
  logic [31:0] rdata;
  logic        unused_inputs;

  assign unused_inputs = ^{bus_byteEnables_i, bus_endTransaction_i, bus_dataValid_i, bus_addrData_i};

  assign resp  = (bus_state_q == BUS_RESP);
  assign wr_en = resp & ~bad_q & ~rnw_q;
  assign rd_en = resp & ~bad_q & rnw_q;

  assign tx_empty  = (tx_wr_q == tx_rd_q);
  assign tx_full   = (tx_wr_q[AW-1:0] == tx_rd_q[AW-1:0]) && (tx_wr_q[AW] != tx_rd_q[AW]);
  assign rx_empty  = (rx_wr_q == rx_rd_q);
  assign rx_full   = (rx_wr_q[AW-1:0] == rx_rd_q[AW-1:0]) && (rx_wr_q[AW] != rx_rd_q[AW]);
  assign tx_count  = tx_wr_q - tx_rd_q;
  assign rx_count  = rx_wr_q - rx_rd_q;
  assign rx_count8 = 8'(rx_count);
  assign tx_free8  = 8'(FIFO_DEPTH) - 8'(tx_count);
  assign tx_idle   = tx_empty & (tx_state_q == S_IDLE);

  // A push into a full FIFO is accepted only when the same cycle frees a slot.
  assign tx_push_ok = wr_en & (reg_q == 2'd0) & (~tx_full | tx_pop);
  assign rx_pop     = rd_en & (reg_q == 2'd0) & ~rx_empty;
  assign rx_push_ok = rx_push_req & (~rx_full | rx_pop);

  assign bus_endTransaction_o = resp;
  assign bus_dataValid_o      = resp;
  assign bus_error_o          = resp & bad_q;
  assign bus_busy_o           = 1'b0;
  assign bus_addrData_o       = rdata;
  assign irq                  = irq_q;
  assign TX                   = tx_line_q;

  // Read data mux, driven only during a well-formed response.
  always_comb begin
    rdata = 32'h0;
    if (resp && !bad_q) begin
      case (reg_q)
        2'd0:    rdata = rx_empty ? 32'h0 : {24'h0, rx_mem[rx_rd_q[AW-1:0]]};
        2'd1:    rdata = {{(32-DIV_W){1'b0}}, div_q};
        2'd2:    rdata = {12'h0, tx_idle, txovf_q, frm_q, rxovr_q, tx_free8, rx_count8};
        default: rdata = {29'h0, ctrl_q};
      endcase
    end
  end

  // Bus FSM, register writes, flag set/clear (set wins) and interrupt level.
  always_comb begin
    bus_state_d = bus_state_q;
    reg_d   = reg_q;
    rnw_d   = rnw_q;
    bad_d   = bad_q;
    div_d   = div_q;
    ctrl_d  = ctrl_q;
    tx_wr_d = tx_wr_q + {{AW{1'b0}}, tx_push_ok};
    tx_rd_d = tx_rd_q + {{AW{1'b0}}, tx_pop};
    rx_wr_d = rx_wr_q + {{AW{1'b0}}, rx_push_ok};
    rx_rd_d = rx_rd_q + {{AW{1'b0}}, rx_pop};
    rxovr_d = rxovr_q;
    frm_d   = frm_q;
    txovf_d = txovf_q;
    case (bus_state_q)
      BUS_IDLE: if (bus_beginTransaction_i && bus_addrData_i[23:20] == BASE_NIBBLE) begin
        bus_state_d = BUS_RESP;
        reg_d = bus_addrData_i[3:2];
        rnw_d = bus_readNWrite_i;
        bad_d = (bus_burstSize_i != 8'd0);
      end
      default: bus_state_d = BUS_IDLE;
    endcase
    if (wr_en && reg_q == 2'd1) div_d = bus_addrData_i[DIV_W-1:0];
    if (wr_en && reg_q == 2'd3) ctrl_d = bus_addrData_i[2:0];
    if (wr_en && reg_q == 2'd2) begin
      rxovr_d = rxovr_q & ~bus_addrData_i[16];
      frm_d   = frm_q   & ~bus_addrData_i[17];
      txovf_d = txovf_q & ~bus_addrData_i[18];
    end
    if (rx_push_req && !rx_push_ok) rxovr_d = 1'b1;
    if (frm_set) frm_d = 1'b1;
    if (wr_en && reg_q == 2'd0 && !tx_push_ok) txovf_d = 1'b1;
    irq_d = (ctrl_q[0] & (rx_count != '0)) | (ctrl_q[1] & tx_idle) |
            (ctrl_q[2] & (rxovr_q | frm_q | txovf_q));
  end

  // TX engine: start, 8 data bits LSB first, stop; each bit DIV+1 clocks.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_line_d  = tx_line_q;
    tx_pop     = 1'b0;
    case (tx_state_q)
      S_IDLE: begin
        tx_line_d = 1'b1;
        if (!tx_empty) begin
          tx_pop = 1'b1; tx_shift_d = tx_mem[tx_rd_q[AW-1:0]];
          tx_cnt_d = div_q; tx_line_d = 1'b0; tx_state_d = S_START;
        end
      end
      S_START: begin
        if (tx_cnt_q == '0) begin
          tx_state_d = S_DATA; tx_cnt_d = div_q; tx_bit_d = 3'd0; tx_line_d = tx_shift_q[0];
        end else tx_cnt_d = tx_cnt_q - 1'b1;
      end
      S_DATA: begin
        if (tx_cnt_q == '0) begin
          tx_cnt_d = div_q;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = S_STOP; tx_line_d = 1'b1;
          end else begin
            tx_bit_d = tx_bit_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_line_d = tx_shift_q[1];
          end
        end else tx_cnt_d = tx_cnt_q - 1'b1;
      end
      default: begin
        if (tx_cnt_q == '0) begin
          // The next queued byte starts straight after the stop bit.
          if (!tx_empty) begin
            tx_pop = 1'b1; tx_shift_d = tx_mem[tx_rd_q[AW-1:0]];
            tx_cnt_d = div_q; tx_line_d = 1'b0; tx_state_d = S_START;
          end else begin
            tx_state_d = S_IDLE; tx_line_d = 1'b1;
          end
        end else tx_cnt_d = tx_cnt_q - 1'b1;
      end
    endcase
  end

  // RX engine: the first count is DIV/2 so that, with the two-flop
  // synchroniser delay, the start check lands near the middle of the bit.
  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    rx_push_req = 1'b0;
    frm_set     = 1'b0;
    case (rx_state_q)
      S_IDLE: if (rx_prev_q && !rx_s2_q) begin
        rx_state_d = S_START; rx_cnt_d = div_q >> 1;
      end
      S_START: begin
        if (rx_cnt_q == '0) begin
          if (rx_s2_q) rx_state_d = S_IDLE;
          else begin rx_state_d = S_DATA; rx_cnt_d = div_q; rx_bit_d = 3'd0; end
        end else rx_cnt_d = rx_cnt_q - 1'b1;
      end
      S_DATA: begin
        if (rx_cnt_q == '0) begin
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          rx_cnt_d = div_q;
          if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
          else rx_bit_d = rx_bit_q + 3'd1;
        end else rx_cnt_d = rx_cnt_q - 1'b1;
      end
      default: begin
        if (rx_cnt_q == '0) begin
          rx_state_d = S_IDLE;
          if (rx_s2_q) rx_push_req = 1'b1;
          else frm_set = 1'b1;
        end else rx_cnt_d = rx_cnt_q - 1'b1;
      end
    endcase
  end

  // State registers; reset aborts both serial engines at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_state_q <= BUS_IDLE; reg_q <= 2'd0; rnw_q <= 1'b0; bad_q <= 1'b0;
      div_q <= DEFAULT_DIV; ctrl_q <= 3'd0;
      rxovr_q <= 1'b0; frm_q <= 1'b0; txovf_q <= 1'b0; irq_q <= 1'b0;
      tx_wr_q <= '0; tx_rd_q <= '0; rx_wr_q <= '0; rx_rd_q <= '0;
      tx_state_q <= S_IDLE; tx_cnt_q <= '0; tx_bit_q <= 3'd0; tx_shift_q <= 8'h0; tx_line_q <= 1'b1;
      rx_state_q <= S_IDLE; rx_cnt_q <= '0; rx_bit_q <= 3'd0; rx_shift_q <= 8'h0;
      rx_s1_q <= 1'b1; rx_s2_q <= 1'b1; rx_prev_q <= 1'b1;
    end else begin
      bus_state_q <= bus_state_d; reg_q <= reg_d; rnw_q <= rnw_d; bad_q <= bad_d;
      div_q <= div_d; ctrl_q <= ctrl_d;
      rxovr_q <= rxovr_d; frm_q <= frm_d; txovf_q <= txovf_d; irq_q <= irq_d;
      tx_wr_q <= tx_wr_d; tx_rd_q <= tx_rd_d; rx_wr_q <= rx_wr_d; rx_rd_q <= rx_rd_d;
      tx_state_q <= tx_state_d; tx_cnt_q <= tx_cnt_d; tx_bit_q <= tx_bit_d;
      tx_shift_q <= tx_shift_d; tx_line_q <= tx_line_d;
      rx_state_q <= rx_state_d; rx_cnt_q <= rx_cnt_d; rx_bit_q <= rx_bit_d; rx_shift_q <= rx_shift_d;
      rx_s1_q <= RX; rx_s2_q <= rx_s1_q; rx_prev_q <= rx_s2_q;
    end
  end

  // FIFO storage; contents need no reset because the pointers gate them.
  always_ff @(posedge clk) begin
    if (tx_push_ok) tx_mem[tx_wr_q[AW-1:0]] <= bus_addrData_i[7:0];
    if (rx_push_ok) rx_mem[rx_wr_q[AW-1:0]] <= rx_shift_q;
  end
endmodule
